// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-enable data memory: access sizes, sequencer
// states, lane count and the alignment rule used by the store and load paths.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int LANES = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // A request is bad when the lane offset does not suit the size, or the
   // size code is the reserved value.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit word, moves it
// to bit 0 and sign- or zero-extends it. Words pass through unchanged.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] result
);

   logic        [7:0]  byte_v;
   logic        [15:0] half_v;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   // Lane selection and extension; the signed views carry the sign bit into
   // the 32-bit result when the load is signed.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = addr_lo[1] ? word[31:16] : word[15:0];
      byte_s = signed'(byte_v);
      half_s = signed'(half_v);
      result = '0;
      case (size)
         SZ_BYTE: begin
            if (uns) result = {24'd0, byte_v};
            else     result = 32'(byte_s);
         end
         SZ_HALF: begin
            if (uns) result = {16'd0, half_v};
            else     result = 32'(half_s);
         end
         SZ_WORD: result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory for the MEM stage. Per-lane write enables,
// registered (read-first) RAM read, alignment/extension after the RAM.
// After reset a sequencer zeroes every word so the array needs no reset.
// Optional macro DMEM_FWD_EN: a store in the same cycle as a load is merged
// per lane into the load result (otherwise the load sees the old word).
module data_memory_be
   import dmem_pkg::*;
#(
   parameter int RAM_SIZE_BIT = 8,
   parameter int RAM_SIZE     = 2**RAM_SIZE_BIT,
   parameter int DATA_WIDTH   = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] Read_data,
   output logic        Read_valid,
   output logic        Busy,
   output logic        Misalign
);

   logic [LANES-1:0][7:0]  mem [RAM_SIZE];

   state_t                 state;
   logic [RAM_SIZE_BIT-1:0] clr_cnt;
   logic                   busy_q;

   logic [RAM_SIZE_BIT-1:0] idx;
   logic [1:0]             lo;
   logic                   bad, ready, do_store, do_load, req_bad;
   logic [LANES-1:0]       st_lanes;
   logic [LANES-1:0][7:0]  st_data;
   logic [RAM_SIZE_BIT-1:0] wr_idx;
   logic [LANES-1:0]       wr_lanes;
   logic [LANES-1:0][7:0]  wr_data;

   logic [LANES-1:0][7:0]  raw_p1;
   logic [LANES-1:0][7:0]  merged_p1;
   logic                   vld_p1, mis_p1, ok_p1, uns_p1;
   logic [1:0]             lo_p1, size_p1;
   logic [31:0]            aligned_p1;
   logic                   unused_addr;

   assign idx         = Address[RAM_SIZE_BIT+1:2];
   assign lo          = Address[1:0];
   assign unused_addr = ^Address[31:RAM_SIZE_BIT+2];
   assign bad         = is_misaligned(Size, lo);
   assign ready       = (state == ST_READY);
   assign do_store    = ready & MemWrite & ~bad;
   assign do_load     = ready & MemRead & ~bad;
   assign req_bad     = ready & (MemRead | MemWrite) & bad;

   // Store lane enables; data is replicated so every enabled lane sees its byte.
   always_comb begin
      st_lanes = '0;
      st_data  = Write_data;
      case (Size)
         SZ_BYTE: begin
            st_lanes[lo] = 1'b1;
            st_data      = {4{Write_data[7:0]}};
         end
         SZ_HALF: begin
            st_lanes = lo[1] ? 4'b1100 : 4'b0011;
            st_data  = {2{Write_data[15:0]}};
         end
         SZ_WORD: st_lanes = 4'b1111;
         default: st_lanes = '0;
      endcase
   end

   // Write port is shared between the clear sequencer and accepted stores.
   always_comb begin
      wr_idx   = idx;
      wr_lanes = '0;
      wr_data  = st_data;
      if (state == ST_CLEAR) begin
         wr_idx   = clr_cnt;
         wr_lanes = '1;
         wr_data  = '0;
      end else if (do_store) begin
         wr_lanes = st_lanes;
      end
   end

   // RAM array: per-lane writes and a read-first registered read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (wr_lanes[i]) mem[wr_idx][i] <= wr_data[i];
      end
      raw_p1 <= mem[idx];
   end

   // Clear sequencer: one word per cycle from 0 to RAM_SIZE-1, then READY.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         busy_q  <= 1'b1;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == RAM_SIZE_BIT'(RAM_SIZE - 1)) begin
            state  <= ST_READY;
            busy_q <= 1'b0;
         end
      end
   end

   // ---- stage boundary: request -> registered response ----
   // Response control: valid/misalign pulses and whether read data is live.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         mis_p1 <= 1'b0;
         ok_p1  <= 1'b0;
      end else begin
         vld_p1 <= ready & MemRead;
         mis_p1 <= req_bad;
         ok_p1  <= do_load;
      end
   end

   // Load attributes that travel alongside the RAM read.
   always_ff @(posedge clk) begin
      lo_p1   <= lo;
      size_p1 <= Size;
      uns_p1  <= Unsigned;
   end

`ifdef DMEM_FWD_EN
   logic [LANES-1:0]      fwd_lanes_p1;
   logic [LANES-1:0][7:0] fwd_data_p1;

   // Capture the same-cycle store so its lanes override the read-first word.
   always_ff @(posedge clk) begin
      fwd_lanes_p1 <= do_store ? st_lanes : '0;
      fwd_data_p1  <= st_data;
   end

   // Per-lane merge of the new store data into the load word.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         merged_p1[i] = fwd_lanes_p1[i] ? fwd_data_p1[i] : raw_p1[i];
      end
   end
`else
   assign merged_p1 = raw_p1;
`endif

   dmem_load_align u_align (
      .word    (merged_p1),
      .addr_lo (lo_p1),
      .size    (size_p1),
      .uns     (uns_p1),
      .result  (aligned_p1)
   );

   assign Read_data  = ok_p1 ? aligned_p1 : '0;
   assign Read_valid = vld_p1;
   assign Misalign   = mis_p1;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed, table-driven bench for data_memory_be.
module tb_data_memory_be;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite, Unsigned;
   logic [31:0] Address, Write_data;
   logic [1:0]  Size;
   logic [31:0] Read_data;
   logic        Read_valid, Busy, Misalign;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_memory_be dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Size       (Size),
      .Unsigned   (Unsigned),
      .Read_data  (Read_data),
      .Read_valid (Read_valid),
      .Busy       (Busy),
      .Misalign   (Misalign)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_data;
      logic        exp_vld;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                               input logic [31:0] exp_data, input logic exp_vld, input logic exp_mis);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
      v.exp_data = exp_data; v.exp_vld = exp_vld; v.exp_mis = exp_mis;
      return v;
   endfunction

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns);
      MemRead = rd; MemWrite = wr; Address = addr; Write_data = wdata; Size = size; Unsigned = uns;
   endtask

   // Count cycles until Busy drops; flags any response activity while busy.
   task automatic count_busy(output int n, output int activity);
      n = 0;
      activity = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (Read_valid !== 1'b0 || Misalign !== 1'b0 || Read_data !== 32'h0) activity++;
      end while (Busy === 1'b1 && n < 1000);
   endtask

   initial begin
      int n_busy, act;
      logic [31:0] fwd_exp;

`ifdef DMEM_FWD_EN
      fwd_exp = 32'hAAAAAAAA;
`else
      fwd_exp = 32'h11111111;
`endif

      //         rd wr addr          wdata         sz  u  exp_data      vld mis
      vecs.push_back(mk(1, 0, 32'h20,  32'h0,        2, 0, 32'h00000000, 1, 0));
      vecs.push_back(mk(0, 1, 32'h10,  32'h12345678, 2, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 0, 32'h13,  32'h0,        0, 0, 32'h00000012, 1, 0));
      vecs.push_back(mk(0, 1, 32'h11,  32'h00000080, 0, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        2, 0, 32'h12348078, 1, 0));
      vecs.push_back(mk(1, 0, 32'h11,  32'h0,        0, 0, 32'hFFFFFF80, 1, 0));
      vecs.push_back(mk(1, 0, 32'h11,  32'h0,        0, 1, 32'h00000080, 1, 0));
      vecs.push_back(mk(0, 1, 32'h12,  32'h0000BEEF, 1, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 0, 32'h12,  32'h0,        1, 0, 32'hFFFFBEEF, 1, 0));
      vecs.push_back(mk(1, 0, 32'h12,  32'h0,        1, 1, 32'h0000BEEF, 1, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        2, 0, 32'hBEEF8078, 1, 0));
      vecs.push_back(mk(1, 0, 32'h11,  32'h0,        1, 0, 32'h00000000, 1, 1));
      vecs.push_back(mk(0, 1, 32'h06,  32'hFFFFFFFF, 2, 0, 32'h00000000, 0, 1));
      vecs.push_back(mk(1, 0, 32'h04,  32'h0,        2, 0, 32'h00000000, 1, 0));
      vecs.push_back(mk(0, 0, 32'h10,  32'h0,        2, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        3, 0, 32'h00000000, 1, 1));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        0, 1, 32'h00000078, 1, 0));
      vecs.push_back(mk(1, 0, 32'h12,  32'h0,        0, 0, 32'hFFFFFFEF, 1, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        1, 1, 32'h00008078, 1, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        1, 0, 32'hFFFF8078, 1, 0));
      vecs.push_back(mk(0, 1, 32'h40,  32'h11111111, 2, 0, 32'h00000000, 0, 0));
      vecs.push_back(mk(1, 1, 32'h40,  32'hAAAAAAAA, 2, 0, fwd_exp,      1, 0));
      vecs.push_back(mk(1, 0, 32'h40,  32'h0,        2, 0, 32'hAAAAAAAA, 1, 0));
      vecs.push_back(mk(1, 0, 32'h410, 32'h0,        2, 0, 32'hBEEF8078, 1, 0));
      vecs.push_back(mk(1, 0, 32'h10,  32'h0,        2, 1, 32'hBEEF8078, 1, 0));

      // Reset state
      reset = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 2, 0);
      #12;
      check("reset Busy",       {31'd0, Busy},       32'd1);
      check("reset Read_valid", {31'd0, Read_valid}, 32'd0);
      check("reset Misalign",   {31'd0, Misalign},   32'd0);
      check("reset Read_data",  Read_data,           32'd0);

      // Clear period with a store+load to 0x20 held active the whole time
      drive(1, 1, 32'h20, 32'hDEADBEEF, 2, 0);
      @(negedge clk);
      reset = 1'b1;
      count_busy(n_busy, act);
      drive(0, 0, 32'h0, 32'h0, 2, 0);
      check("busy cycles after reset", 32'(n_busy), 32'd256);
      check("no response while busy",  32'(act),    32'd0);

      // Directed vectors
      foreach (vecs[i]) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns);
         @(posedge clk); #1;
         check($sformatf("vec%0d Read_data", i),  Read_data,                 vecs[i].exp_data);
         check($sformatf("vec%0d Read_valid", i), {31'd0, Read_valid},       {31'd0, vecs[i].exp_vld});
         check($sformatf("vec%0d Misalign", i),   {31'd0, Misalign},         {31'd0, vecs[i].exp_mis});
      end

      // Async reset mid-operation, while a load response is live
      drive(1, 0, 32'h10, 32'h0, 2, 0);
      @(posedge clk); #1;
      check("pre-reset load", Read_data, 32'hBEEF8078);
      reset = 1'b0;
      #2;
      check("mid reset Busy",       {31'd0, Busy},       32'd1);
      check("mid reset Read_valid", {31'd0, Read_valid}, 32'd0);
      check("mid reset Read_data",  Read_data,           32'd0);
      @(negedge clk);
      reset = 1'b1;
      count_busy(n_busy, act);
      check("busy cycles after second reset", 32'(n_busy), 32'd256);
      check("no response during second clear", 32'(act),   32'd0);

      // Every word reads back as zero after the clear
      for (int w = 0; w < 256; w++) begin
         drive(1, 0, 32'(w * 4), 32'h0, 2, 0);
         @(posedge clk); #1;
         check($sformatf("cleared word %0d", w), Read_data, 32'h0);
      end
      drive(0, 0, 32'h0, 32'h0, 2, 0);
      @(posedge clk); #1;
      check("idle after sweep Read_valid", {31'd0, Read_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
